// File: rtl/viol_handler.sv
// -----------------------------------------------------------------------------
// viol_handler
//
// Captures the first memory-access violation reported by the access checker.
// On a capture it logs the faulting data address and PC, counts the event,
// raises a sticky interrupt flag, and holds the CPU in reset for RST_CYCLES
// mclk cycles. The log lives in a small peripheral register block. Only
// trusted code, running while in_safe_area is high, can modify these
// registers.
//
// Parameters
//   BASE_ADDR    peripheral word base address; registers at BASE_ADDR+0..+3
//   RST_CYCLES   CPU reset hold length in mclk cycles (2..255)
//
// Ports
//   mclk          single clock, rising edge
//   por           asynchronous active-high power-on reset; independent of
//                 cpu_rst_req so that the log survives CPU resets
//   viol_req      violation request from the memory-access checker
//   viol_addr     data address at the violation
//   viol_pc       instruction address at the violation
//   in_safe_area  high while trusted code executes
//   per_en        peripheral access enable
//   per_we        byte write enables; any nonzero value is a full-word write
//   per_addr      peripheral word address
//   per_din       peripheral write data
//   per_dout      peripheral read data; 0 when not selected or on a write
//   cpu_rst_req   registered CPU reset request, high while in HOLD
//   viol_irq      level interrupt equal to STATUS.VIOL
//
// Register map (word offsets)
//   0 STATUS  bit0 VIOL (sticky, write-1-to-clear), bit1 BUSY (read-only),
//             bit2 live in_safe_area (read-only)
//   1 ADDR    captured data address (read-only)
//   2 PC      captured instruction address (read-only)
//   3 COUNT   saturating violation count; any write clears it
// -----------------------------------------------------------------------------
module viol_handler #(
  parameter logic [13:0] BASE_ADDR  = 14'h0090,
  parameter int          RST_CYCLES = 16
) (
  input  logic        mclk,
  input  logic        por,
  input  logic        viol_req,
  input  logic [15:0] viol_addr,
  input  logic [15:0] viol_pc,
  input  logic        in_safe_area,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic        cpu_rst_req,
  output logic        viol_irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The counter runs RST_CYCLES-1 down to 0, so HOLD lasts RST_CYCLES cycles.
  localparam logic [7:0]  HOLD_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Reduction parity over a data word.
  function automatic logic parity15(input logic [14:0] d);
    return ^d;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  hold_cnt_r;
  logic [7:0]  hold_cnt_nxt_s;
  logic        capture_s;
  logic        rst_req_r;
  logic        viol_r;
  logic [15:0] addr_r;
  logic [15:0] pc_r;
  logic [15:0] count_r;

  logic [13:0] offset_s;
  logic        sel_s;
  logic        wr_s;
  logic        wr_status_s;
  logic        wr_count_s;
  logic        busy_s;
  logic [15:0] rd_data_s;

  // Only bit 0 of the write data is meaningful (W1C on STATUS). The other
  // bits are folded here so that they are visibly consumed.
  logic        unused_din_s;
  assign unused_din_s = parity15(per_din[15:1]);

  // Next-state and hold-counter logic. A capture is accepted only in IDLE,
  // so the first fault of a reset episode is preserved.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    capture_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (viol_req) begin
          capture_s      = 1'b1;
          hold_cnt_nxt_s = HOLD_LOAD;
          state_nxt_s    = HOLD;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_r == 8'd0) begin
          state_nxt_s    = RELEASE;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 8'd1;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s    = IDLE;
        hold_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State register, hold counter and the registered CPU reset request.
  // por clears rst_req_r asynchronously, so the CPU reset drops at once.
  always_ff @(posedge mclk or posedge por) begin
    if (por) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      rst_req_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rst_req_r  <= (state_nxt_s == HOLD);
    end
  end

  // Address decode. The unsigned offset is below 4 only inside the window.
  assign offset_s    = per_addr - BASE_ADDR;
  assign sel_s       = per_en & (offset_s < 14'd4);
  assign wr_s        = sel_s & (|per_we) & in_safe_area;
  assign wr_status_s = wr_s & (offset_s[1:0] == 2'd0);
  assign wr_count_s  = wr_s & (offset_s[1:0] == 2'd3);
  assign busy_s      = (state_r != IDLE);

  // Violation log registers. A capture takes priority over a W1C to VIOL.
  // A capture that coincides with a COUNT clear leaves COUNT at 1.
  always_ff @(posedge mclk or posedge por) begin
    if (por) begin
      viol_r  <= 1'b0;
      addr_r  <= 16'h0000;
      pc_r    <= 16'h0000;
      count_r <= 16'h0000;
    end else begin
      if (capture_s) begin
        viol_r <= 1'b1;
        addr_r <= viol_addr;
        pc_r   <= viol_pc;
        if (wr_count_s) begin
          count_r <= 16'h0001;
        end else if (count_r != COUNT_MAX) begin
          count_r <= count_r + 16'h0001;
        end else begin
          count_r <= count_r;
        end
      end else begin
        if (wr_status_s && per_din[0]) begin
          viol_r <= 1'b0;
        end else begin
          viol_r <= viol_r;
        end
        if (wr_count_s) begin
          count_r <= 16'h0000;
        end else begin
          count_r <= count_r;
        end
      end
    end
  end

  // Combinational read mux. It returns 0 when the block is not selected or
  // when the access is a write.
  always_comb begin
    rd_data_s = 16'h0000;
    if (sel_s && (per_we == 2'b00)) begin
      case (offset_s[1:0])
        2'd0:    rd_data_s = {13'h0000, in_safe_area, busy_s, viol_r};
        2'd1:    rd_data_s = addr_r;
        2'd2:    rd_data_s = pc_r;
        2'd3:    rd_data_s = count_r;
        default: rd_data_s = 16'h0000;
      endcase
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  assign per_dout    = rd_data_s;
  assign cpu_rst_req = rst_req_r;
  assign viol_irq    = viol_r;

endmodule

// File: tb/tb_viol_handler.sv
module tb_viol_handler;

  localparam logic [13:0] A_STATUS = 14'h0090;
  localparam logic [13:0] A_ADDR   = 14'h0091;
  localparam logic [13:0] A_PC     = 14'h0092;
  localparam logic [13:0] A_COUNT  = 14'h0093;
  localparam logic [13:0] A_OUT_HI = 14'h0094;
  localparam logic [13:0] A_OUT_LO = 14'h008F;

  logic        mclk;
  logic        por;
  logic        viol_req;
  logic [15:0] viol_addr;
  logic [15:0] viol_pc;
  logic        in_safe_area;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        cpu_rst_req;
  logic        viol_irq;

  int total = 0;
  int bad   = 0;

  viol_handler #(.BASE_ADDR(14'h0090), .RST_CYCLES(16)) dut (
    .mclk        (mclk),
    .por         (por),
    .viol_req    (viol_req),
    .viol_addr   (viol_addr),
    .viol_pc     (viol_pc),
    .in_safe_area(in_safe_area),
    .per_en      (per_en),
    .per_we      (per_we),
    .per_addr    (per_addr),
    .per_din     (per_din),
    .per_dout    (per_dout),
    .cpu_rst_req (cpu_rst_req),
    .viol_irq    (viol_irq)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b00; per_addr = a;
    #1;
    d = per_dout;
    per_en = 1'b0; per_addr = 14'h0000;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    @(negedge mclk);
    per_en = 1'b1; per_we = we; per_addr = a; per_din = d;
    @(posedge mclk);
    #1;
    per_en = 1'b0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
  endtask

  task automatic viol_pulse(input logic [15:0] a, input logic [15:0] p);
    @(negedge mclk);
    viol_addr = a; viol_pc = p; viol_req = 1'b1;
    @(posedge mclk);
    #1;
    viol_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    por = 1'b1; viol_req = 1'b0; viol_addr = 16'h0000; viol_pc = 16'h0000;
    in_safe_area = 1'b0; per_en = 1'b0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
    repeat (2) @(posedge mclk);
    #1;
    total++; if (cpu_rst_req !== 1'b0) begin bad++; $display("FAIL reset_rst_req: got %b want 0", cpu_rst_req); end
    total++; if (viol_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", viol_irq); end
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_status: got %h want 0000", d); end
    bus_read(A_ADDR, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", d); end
    bus_read(A_PC, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", d); end
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h want 0000", d); end
    por = 1'b0;
  endtask

  // First capture, a second request during HOLD, and the reset pulse length.
  task automatic test_capture();
    logic [15:0] d;
    int high_cnt;
    int guard;
    viol_pulse(16'h00C8, 16'hF000);
    high_cnt = 0;
    guard = 0;
    while (cpu_rst_req === 1'b1 && guard < 40) begin
      high_cnt++;
      guard++;
      if (high_cnt == 3) viol_pulse(16'h1234, 16'hBEEF);
      else begin @(posedge mclk); #1; end
    end
    total++; if (guard >= 40) begin bad++; $display("FAIL hold_timeout: cycles %0d bound 40", guard); end
    total++; if (high_cnt != 16) begin bad++; $display("FAIL rst_req_len: got %0d want 16", high_cnt); end
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0003) begin bad++; $display("FAIL release_status: got %h want 0003", d); end
    @(posedge mclk); #1;
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL idle_status: got %h want 0001", d); end
    total++; if (viol_irq !== 1'b1) begin bad++; $display("FAIL capture_irq: got %b want 1", viol_irq); end
    bus_read(A_ADDR, d);
    total++; if (d !== 16'h00C8) begin bad++; $display("FAIL capture_addr: got %h want 00C8", d); end
    bus_read(A_PC, d);
    total++; if (d !== 16'hF000) begin bad++; $display("FAIL capture_pc: got %h want F000", d); end
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL capture_count: got %h want 0001", d); end
  endtask

  task automatic test_w1c();
    logic [15:0] d;
    bus_write(A_STATUS, 16'h0001, 2'b11);
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL w1c_unsafe: got %h want 0001", d); end
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b11; per_addr = A_STATUS; per_din = 16'h0000;
    #1;
    total++; if (per_dout !== 16'h0000) begin bad++; $display("FAIL dout_on_write: got %h want 0000", per_dout); end
    per_en = 1'b0; per_we = 2'b00;
    bus_read(A_OUT_HI, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL read_base_plus4: got %h want 0000", d); end
    bus_read(A_OUT_LO, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL read_base_minus1: got %h want 0000", d); end
    in_safe_area = 1'b1;
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0005) begin bad++; $display("FAIL status_safe: got %h want 0005", d); end
    bus_write(A_ADDR, 16'hFFFF, 2'b11);
    bus_write(A_PC, 16'h0000, 2'b10);
    bus_read(A_ADDR, d);
    total++; if (d !== 16'h00C8) begin bad++; $display("FAIL addr_readonly: got %h want 00C8", d); end
    bus_read(A_PC, d);
    total++; if (d !== 16'hF000) begin bad++; $display("FAIL pc_readonly: got %h want F000", d); end
    bus_write(A_STATUS, 16'h0001, 2'b01);
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0004) begin bad++; $display("FAIL w1c_safe: got %h want 0004", d); end
    total++; if (viol_irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", viol_irq); end
  endtask

  task automatic test_count_sat();
    logic [15:0] d;
    @(negedge mclk);
    force dut.count_r = 16'hFFFF;
    @(posedge mclk); #1;
    release dut.count_r;
    viol_pulse(16'h0100, 16'h0200);
    bus_read(A_COUNT, d);
    total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL count_saturate: got %h want FFFF", d); end
    total++; if (viol_irq !== 1'b1) begin bad++; $display("FAIL recapture_irq: got %b want 1", viol_irq); end
    repeat (20) @(posedge mclk);
    #1;
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b11; per_addr = A_COUNT; per_din = 16'h0000;
    viol_addr = 16'h0300; viol_pc = 16'h0400; viol_req = 1'b1;
    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00; viol_req = 1'b0;
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL clear_with_capture: got %h want 0001", d); end
    bus_write(A_COUNT, 16'h5A5A, 2'b10);
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL count_clear: got %h want 0000", d); end
    repeat (20) @(posedge mclk);
    #1;
  endtask

  task automatic test_por_mid_hold();
    logic [15:0] d;
    in_safe_area = 1'b0;
    viol_pulse(16'h0A0A, 16'h5555);
    repeat (4) @(posedge mclk);
    #1;
    total++; if (cpu_rst_req !== 1'b1) begin bad++; $display("FAIL hold_rst_req: got %b want 1", cpu_rst_req); end
    #2 por = 1'b1;
    #1;
    total++; if (cpu_rst_req !== 1'b0) begin bad++; $display("FAIL por_async_drop: got %b want 0", cpu_rst_req); end
    total++; if (viol_irq !== 1'b0) begin bad++; $display("FAIL por_irq: got %b want 0", viol_irq); end
    bus_read(A_STATUS, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL por_status: got %h want 0000", d); end
    bus_read(A_ADDR, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL por_addr: got %h want 0000", d); end
    bus_read(A_PC, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL por_pc: got %h want 0000", d); end
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL por_count: got %h want 0000", d); end
    bus_read(A_OUT_HI, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL por_base_plus4: got %h want 0000", d); end
    // Release por and request a capture for the very next edge.
    @(negedge mclk);
    por = 1'b0; viol_addr = 16'h0077; viol_pc = 16'h0088; viol_req = 1'b1;
    @(posedge mclk); #1;
    viol_req = 1'b0;
    total++; if (cpu_rst_req !== 1'b1) begin bad++; $display("FAIL post_por_rst_req: got %b want 1", cpu_rst_req); end
    bus_read(A_ADDR, d);
    total++; if (d !== 16'h0077) begin bad++; $display("FAIL post_por_addr: got %h want 0077", d); end
    bus_read(A_COUNT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL post_por_count: got %h want 0001", d); end
    repeat (20) @(posedge mclk);
    #1;
    total++; if (cpu_rst_req !== 1'b0) begin bad++; $display("FAIL post_por_release: got %b want 0", cpu_rst_req); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_w1c();
    test_count_sat();
    test_por_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
